// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the fetch stage: word type, BIOS ROM window,
// and the fetch-to-decode payload.
package instr_fetch_pkg;

  typedef logic [31:0] word_t;

  localparam word_t       BIOS_RESET_VECTOR = 32'h0000_0000;
  localparam word_t       BIOS_BASE         = 32'h0000_0000;
  localparam int unsigned BIOS_BYTES        = 4096;

  typedef struct packed {
    word_t pc;
    word_t ir;
    logic  fault;
  } if_id_t;

  // Offset form makes the window test a single unsigned compare, even for
  // windows that end exactly at the top of the address space.
  function automatic logic in_window(input word_t addr, input word_t base,
                                     input int unsigned bytes);
    word_t offset;
    offset = addr - base;
    return offset < word_t'(bytes);
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch in front of the BIOS ROM: issues word addresses, pairs the
// 1-cycle-late ROM data with its PC, and re-issues the held address on stall.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter word_t       RESET_VECTOR = BIOS_RESET_VECTOR,
  parameter word_t       ROM_BASE     = BIOS_BASE,
  parameter int unsigned ROM_BYTES    = BIOS_BYTES
) (
  input  logic  clk_i,
  input  logic  reset_i,
  output word_t imem_addr_o,
  input  word_t imem_data_i,
  output logic  if_valid_o,
  output word_t if_pc_o,
  output word_t if_ir_o,
  output logic  if_fault_o,
  input  logic  id_ready_i,
  input  logic  jmp_valid_i,
  input  word_t jmp_addr_i
);

  word_t  fetch_pc_r;
  word_t  next_pc_r;
  logic   fetch_valid_r;
  logic   stall;
  word_t  jmp_target;
  if_id_t if_id;

  // A redirect kills whatever is presented this cycle, ready or not.
  assign if_valid_o = fetch_valid_r & ~jmp_valid_i;
  assign stall      = if_valid_o & ~id_ready_i;
  assign jmp_target = jmp_addr_i & ~word_t'(3);

  assign if_id.pc    = fetch_pc_r;
  assign if_id.fault = if_valid_o & ~in_window(fetch_pc_r, ROM_BASE, ROM_BYTES);
  assign if_id.ir    = if_id.fault ? '0 : imem_data_i;

  assign if_pc_o    = if_id.pc;
  assign if_ir_o    = if_id.ir;
  assign if_fault_o = if_id.fault;

  // Re-issuing fetch_pc_r on stall makes the ROM return the same word next
  // cycle, so the presented instruction holds without a skid buffer.
  always_comb begin
    // NOTE: assign a default first so no path through the block leaves the
    // output unassigned, which would infer a latch.
    imem_addr_o = next_pc_r;
    if (jmp_valid_i) begin
      imem_addr_o = jmp_target;
    end else if (stall) begin
      imem_addr_o = fetch_pc_r;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_valid_r <= 1'b0;
      fetch_pc_r    <= RESET_VECTOR;
      next_pc_r     <= RESET_VECTOR;
    end else begin
      fetch_valid_r <= 1'b1;
      fetch_pc_r    <= imem_addr_o;
      next_pc_r     <= imem_addr_o + 32'd4;
    end
  end

endmodule
